alu_sll_seq: RTL and testbench
==============================

# alu_sll_seq

Multi-cycle 32-bit logical left shifter for the pipeline execute stage. It is the left-direction counterpart of the combinational arithmetic right shifter. It applies one power-of-two shift stage per clock, shifting by 1, 2, 4, 8, then 16, selected by the shift-amount bits. It runs under a start/busy/done handshake, so the EX stage can stall on `busy_o` instead of closing timing on a full 5-level barrel shift.

## Interface
- `WIDTH`, 32: data width; fixed at 32 (other values unsupported).
- `SHAMT_W`, 5: shift-amount bits used; must equal log2(`WIDTH`).

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request; accepted on a rising edge when `start_i`=1, `busy_o`=0, `flush_i`=0.
- `flush_i`  in  1  synchronous abort of the operation in flight (pipeline flush).
- `a_i`  in  32  operand to shift; sampled only at acceptance.
- `b_i`  in  32  shift amount; only `b_i[4:0]` used, `b_i[31:5]` ignored; sampled only at acceptance.
- `busy_o`  out  1  high while an accepted operation is in progress.
- `done_o`  out  1  one-cycle pulse; `c_o` is valid and new in this cycle.
- `c_o`  out  32  result `a_i << b_i[4:0]`, zero-filled; holds last completed result.

## Operation
- State: IDLE / SHIFT. Internal registers:
  - work register `w[31:0]`
  - captured amount `s[4:0]`
  - stage counter `k[2:0]` (0..4)
- IDLE:
  - On acceptance: `w`<=`a_i`, `s`<=`b_i[4:0]`, `k`<=0, `busy_o`<=1, go to SHIFT.
  - A request is refused if `flush_i`=1 in the same cycle.
- SHIFT, each edge, stage k:
  - `w` <= `s[k]` ? `{w[31-2^k:0], 2^k zeros}` : `w`.
  - `k`<=`k`+1.
- After stage 4 (the edge where `k`=4):
  - `c_o`<=shifted `w`, `done_o`<=1, `busy_o`<=0, go to IDLE.
- `done_o` deasserts on the next edge unconditionally.
- Fixed latency: stages execute even when `s[k]`=0. There is no early exit for shift amount 0.
- `start_i` while `busy_o`=1: ignored, not queued. `a_i`/`b_i` changes while busy have no effect.
- `flush_i`=1 while busy:
  - Next edge: go to IDLE, `busy_o`<=0.
  - No `done_o`; `c_o` unchanged.
- `flush_i`=1 in IDLE: no effect other than blocking acceptance that cycle.
- `flush_i` and completion on the same edge: flush wins; no `done_o`, `c_o` unchanged.
- Width rule: bits shifted past bit 31 are discarded; vacated LSBs are 0. No sign handling.

## Timing
- Reset (async assert, any time, including mid-operation):
  - `busy_o`=0, `done_o`=0, `c_o`=32'h0000_0000.
  - State IDLE, `w`=0, `s`=0, `k`=0.
- Release is synchronous to `clk_i`. The first acceptance is possible on the first rising edge after deassertion.
- `start_i` high in cycle T and accepted:
  - `busy_o`=1 in cycles T+1..T+5.
  - Stages 0..4 execute at the ends of T+1..T+5.
  - `done_o`=1 and `c_o` valid in cycle T+6, with `busy_o`=0.
- Latency 6 cycles, start to done.
- Back-to-back: a new `start_i` may be accepted in the `done_o` cycle (T+6), giving next `done_o` at T+12. Throughput is one result per 6 cycles.
- `c_o` changes only at a completing edge or on reset. It is stable from T+6 until the next `done_o`.
- Flush asserted in cycle F while busy: `busy_o`=0 from cycle F+1.

## Test plan
- Reset, then `a_i`=32'h0000_0001, `b_i`=32'd31, start at T -> `busy_o`=1 T+1..T+5; `done_o`=1 only at T+6 with `c_o`=32'h8000_0000.
- `a_i`=32'hDEAD_BEEF, `b_i`=32'hFFFF_FFE4 (amount 4) -> `c_o`=32'hEADB_EEF0. Then `b_i`=0 -> `c_o`=32'hDEAD_BEEF, still at T+6.
- Back-to-back, stimulus:
  - job 1 at T: `a_i`=32'h0000_00FF, amount 8.
  - job 2 at T+6: amount 24.
  - `start_i` pulsed again during T+2, and `a_i`/`b_i` toggled while busy.

  Required response:
  - `done_o` at T+6 with `c_o`=32'h0000_FF00.
  - `done_o` at T+12 with `c_o`=32'hFF00_0000.
  - The start pulse during busy is ignored.
- Completed result 32'h1234_5678, new start at T, `flush_i`=1 at T+3 -> `busy_o`=0 at T+4; no `done_o` through T+10; `c_o` holds 32'h1234_5678. Flush coincident with the completing edge (cycle T+5) -> no `done_o`, `c_o` unchanged.
- `rst_n_i` pulsed low asynchronously mid-cycle at T+2 of an operation -> `busy_o`, `done_o`, `c_o` go to 0 immediately; no later `done_o`. A fresh start after release completes normally.
- 10,000 random `a_i`/`b_i` pairs with random start gaps, flushes and ignored starts -> every `done_o` has `c_o` == `a_i << b_i[4:0]` of its accepted request. Exactly one `done_o` per unflushed acceptance.

Source files
------------

// File: rtl/alu_sll_seq.sv
// rtl/alu_sll_seq.sv - multi-cycle 32-bit logical left shifter, one power-of-two stage per clock
module alu_sll_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] c_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_w;
  logic [SHAMT_W-1:0] r_s;
  logic [2:0]         r_k;
  logic               r_done;
  logic [WIDTH-1:0]   r_c;

  logic               w_accept;
  logic               w_step;
  logic               w_complete;
  logic [WIDTH-1:0]   w_stage;
  logic               w_unused;

  // Only the low shift-amount bits matter; the rest of b_i is deliberately dropped.
  assign w_unused = ^b_i[WIDTH-1:SHAMT_W];

  always_comb begin
    case (r_k)
      3'd0:    w_stage = r_s[0] ? {r_w[WIDTH-2:0],  1'b0}  : r_w;
      3'd1:    w_stage = r_s[1] ? {r_w[WIDTH-3:0],  2'b0}  : r_w;
      3'd2:    w_stage = r_s[2] ? {r_w[WIDTH-5:0],  4'b0}  : r_w;
      3'd3:    w_stage = r_s[3] ? {r_w[WIDTH-9:0],  8'b0}  : r_w;
      3'd4:    w_stage = r_s[4] ? {r_w[WIDTH-17:0], 16'b0} : r_w;
      default: w_stage = r_w;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_step     = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && !flush_i) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        // A flush on the completing edge still suppresses the result.
        if (flush_i) begin
          w_next = IDLE;
        end else if (r_k == 3'd4) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_s     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_complete;
      if (w_accept) begin
        r_w <= a_i;
        r_s <= b_i[SHAMT_W-1:0];
        r_k <= 3'd0;
      end else if (w_step) begin
        r_w <= w_stage;
        r_k <= r_k + 3'd1;
      end
      if (w_complete) begin
        r_c <= w_stage;
      end
    end
  end

  assign busy_o = (r_state == SHIFT);
  assign done_o = r_done;
  assign c_o    = r_c;

endmodule

// File: tb/tb_alu_sll_seq.sv
// tb/tb_alu_sll_seq.sv - directed and randomized checks for alu_sll_seq
`timescale 1ns/1ps
module tb_alu_sll_seq;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic        flush_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] c_o;

  int total = 0;
  int bad   = 0;

  alu_sll_seq dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .flush_i (flush_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .c_o     (c_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Called at a negedge (cycle T); start is taken on the posedge closing T.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || c_o !== 32'h0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b c=%h, want 0 0 00000000", busy_o, done_o, c_o);
    end
    rst_n_i = 1'b1;
  endtask

  // Runs one op from a negedge; checks busy/done timeline through T+6.
  task automatic test_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    @(negedge clk_i);
    launch(a, b);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk_i);
      total++;
      if (busy_o !== (cyc <= 5) || done_o !== (cyc == 6)) begin
        bad++;
        $display("FAIL %s timing T+%0d: busy=%b done=%b want busy=%b done=%b",
                 nm, cyc, busy_o, done_o, (cyc <= 5), (cyc == 6));
      end
    end
    total++;
    if (c_o !== exp) begin
      bad++;
      $display("FAIL %s result: c=%h want %h", nm, c_o, exp);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    launch(32'h0000_00FF, 32'd8);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk_i);
      if (cyc == 2) begin start_i = 1'b1; a_i = 32'hFFFF_FFFF; b_i = 32'd1; end
      if (cyc == 3) begin start_i = 1'b0; a_i = 32'h0F0F_0F0F; b_i = 32'd3; end
      if (cyc < 6) begin
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
          bad++;
          $display("FAIL b2b job1 T+%0d: busy=%b done=%b want 1 0", cyc, busy_o, done_o);
        end
      end
    end
    total++;
    if (done_o !== 1'b1 || c_o !== 32'h0000_FF00) begin
      bad++;
      $display("FAIL b2b job1 done: done=%b c=%h want 1 0000ff00", done_o, c_o);
    end
    launch(32'h0000_00FF, 32'd24);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk_i);
      total++;
      if (done_o !== (cyc == 6) || busy_o !== (cyc <= 5)) begin
        bad++;
        $display("FAIL b2b job2 T+%0d: busy=%b done=%b", cyc, busy_o, done_o);
      end
    end
    total++;
    if (c_o !== 32'hFF00_0000) begin
      bad++;
      $display("FAIL b2b job2 result: c=%h want ff000000", c_o);
    end
  endtask

  task automatic test_flush();
    test_op("flush_setup", 32'h1234_5678, 32'd0, 32'h1234_5678);
    @(negedge clk_i);
    launch(32'hFFFF_FFFF, 32'd1);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk_i);
      flush_i = (cyc == 3);
      if (cyc == 4) begin
        total++;
        if (busy_o !== 1'b0) begin
          bad++;
          $display("FAIL flush busy T+4: busy=%b want 0", busy_o);
        end
      end
      total++;
      if (done_o !== 1'b0 || c_o !== 32'h1234_5678) begin
        bad++;
        $display("FAIL flush hold T+%0d: done=%b c=%h want 0 12345678", cyc, done_o, c_o);
      end
    end
    launch(32'hFFFF_FFFF, 32'd2);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk_i);
      flush_i = (cyc == 5);
      if (cyc >= 6) begin
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || c_o !== 32'h1234_5678) begin
          bad++;
          $display("FAIL flush_at_complete T+%0d: busy=%b done=%b c=%h want 0 0 12345678",
                   cyc, busy_o, done_o, c_o);
        end
      end
    end
    flush_i = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    launch(32'h0000_0003, 32'd2);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || c_o !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: busy=%b done=%b c=%h want 0 0 00000000", busy_o, done_o, c_o);
    end
    #2 rst_n_i = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk_i);
      total++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL after_reset cycle %0d: busy=%b done=%b want 0 0", cyc, busy_o, done_o);
      end
    end
    test_op("post_reset", 32'h0000_0005, 32'd3, 32'h0000_0028);
  endtask

  task automatic test_random();
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [2:0]  m_k = '0;
    logic [31:0] m_a = '0;
    logic [4:0]  m_s = '0;
    logic [31:0] m_c = 32'h0000_0028;
    int          accepts = 0;
    int          flushed = 0;
    int          dones = 0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(negedge clk_i);
      if (done_o) dones++;
      total++;
      if (busy_o !== m_busy || done_o !== m_done || c_o !== m_c) begin
        bad++;
        $display("FAIL random cycle %0d: busy=%b done=%b c=%h want %b %b %h",
                 cyc, busy_o, done_o, c_o, m_busy, m_done, m_c);
      end
      start_i = ($urandom_range(0, 9) < 4);
      flush_i = ($urandom_range(0, 99) < 3);
      a_i     = $urandom;
      b_i     = $urandom;
      m_done  = 1'b0;
      if (!m_busy) begin
        if (start_i && !flush_i) begin
          m_busy = 1'b1; m_k = '0; m_a = a_i; m_s = b_i[4:0]; accepts++;
        end
      end else if (flush_i) begin
        m_busy = 1'b0; flushed++;
      end else if (m_k == 3'd4) begin
        m_busy = 1'b0; m_done = 1'b1; m_c = m_a << m_s;
      end else begin
        m_k = m_k + 3'd1;
      end
    end
    @(negedge clk_i);
    if (done_o) dones++;
    start_i = 1'b0; flush_i = 1'b0;
    repeat (7) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    total++;
    if (dones !== accepts - flushed) begin
      bad++;
      $display("FAIL random done_count: dones=%0d want %0d", dones, accepts - flushed);
    end
  endtask

  initial begin
    test_reset();
    test_op("shift31", 32'h0000_0001, 32'd31, 32'h8000_0000);
    test_op("shift4", 32'hDEAD_BEEF, 32'hFFFF_FFE4, 32'hEADB_EEF0);
    test_op("shift0", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
